// File: rtl/sccb_init_seq_if.sv
// Table-ROM read port plus the valid/ready/done handshake towards the SCCB byte-write engine.
// The sequencer uses the master modport; the ROM/engine side uses the slave modport.
interface sccb_init_seq_if #(
  parameter int TBL_AW = 8
);
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_reg;
  logic [7:0]        wr_val;
  logic              wr_done;
  logic              wr_nack;

  modport master (
    output tbl_addr, wr_valid, wr_reg, wr_val,
    input  tbl_data, wr_ready, wr_done, wr_nack
  );

  modport slave (
    input  tbl_addr, wr_valid, wr_reg, wr_val,
    output tbl_data, wr_ready, wr_done, wr_nack
  );
endinterface

// File: rtl/sccb_init_seq.sv
// Camera power-up and register-table sequencer: PWDN/RESET timing, table walk, serial SCCB writes.
// Optional NACK retry with error reporting is enabled by defining SCCB_RETRY_EN.
module sccb_init_seq #(
  parameter int TBL_AW       = 8,
  parameter int NUM_ENTRIES  = 171,
  parameter int RST_PRE_CYC  = 50000,
  parameter int RST_LOW_CYC  = 50000,
  parameter int RST_POST_CYC = 50000,
  parameter int DELAY_UNIT   = 50000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_ov,
  sccb_init_seq_if.master   io_bus,
  output logic              o_cam_pwdn,
  output logic              o_cam_rst_n,
  output logic              o_busy,
  output logic              o_init_done,
  output logic              o_init_err,
  output logic [TBL_AW-1:0] o_entry_idx
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]  C_PRE       = CNT_W'(RST_PRE_CYC);
  localparam logic [CNT_W-1:0]  C_LOW       = CNT_W'(RST_LOW_CYC);
  localparam logic [CNT_W-1:0]  C_POST      = CNT_W'(RST_POST_CYC);
  localparam logic [CNT_W-1:0]  C_UNIT      = CNT_W'(DELAY_UNIT);
  localparam logic [TBL_AW-1:0] C_LAST      = TBL_AW'(NUM_ENTRIES - 1);
  localparam logic [RTY_W-1:0]  C_RETRY_LIM = RTY_W'(MAX_RETRY);
  localparam logic [15:0]       C_END_MARK  = 16'hFFFE;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PRE     = 4'd1,
    S_RSTL    = 4'd2,
    S_POST    = 4'd3,
    S_FETCH   = 4'd4,
    S_WAITROM = 4'd5,
    S_DECODE  = 4'd6,
    S_ISSUE   = 4'd7,
    S_WAITW   = 4'd8,
    S_DLY     = 4'd9,
    S_NEXT    = 4'd10,
    S_DONE    = 4'd11,
    S_ERR     = 4'd12
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_dly_cnt;
  logic [TBL_AW-1:0] r_entry_idx;
  logic [TBL_AW-1:0] w_entry_nxt;
  logic [TBL_AW-1:0] r_tbl_addr;
  logic [7:0]        r_wr_reg;
  logic [7:0]        r_wr_val;
  logic [7:0]        w_reg_nxt;
  logic [7:0]        w_val_nxt;
  logic              r_wr_valid;
  logic              r_cam_pwdn;
  logic              r_cam_rst_n;
  logic              r_busy;
  logic              r_init_done;
  logic              r_init_err;
  logic              r_auto;
  logic              r_ov_s1;
  logic              r_ov_s2;
  logic              r_ov_s3;
  logic              r_edge;
`ifdef SCCB_RETRY_EN
  logic [RTY_W-1:0]  r_retry;
  logic [RTY_W-1:0]  w_retry_nxt;
`else
  logic              w_unused;
  assign w_unused = ^{io_bus.wr_nack, C_RETRY_LIM};
`endif

  assign w_dly_cnt = CNT_W'(io_bus.tbl_data[7:0]) * C_UNIT;

  // init_ov synchroniser chain; kept out of reset so a static level never looks like an edge
  always_ff @(posedge i_clk) begin
    r_ov_s1 <= i_init_ov;
    r_ov_s2 <= r_ov_s1;
    r_ov_s3 <= r_ov_s2;
  end

  // Next-state, counter and datapath selection; an init_ov edge overrides every state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_entry_nxt = r_entry_idx;
    w_reg_nxt   = r_wr_reg;
    w_val_nxt   = r_wr_val;
`ifdef SCCB_RETRY_EN
    w_retry_nxt = r_retry;
`endif
    if (r_edge) begin
      w_state_nxt = S_PRE;
      w_cnt_nxt   = C_PRE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_auto) begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = C_PRE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRE: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_RSTL;
            w_cnt_nxt   = C_LOW;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_RSTL: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_POST;
            w_cnt_nxt   = C_POST;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_POST: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_FETCH;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_entry_nxt = {TBL_AW{1'b0}};
`ifdef SCCB_RETRY_EN
            w_retry_nxt = {RTY_W{1'b0}};
`endif
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_FETCH:   w_state_nxt = S_WAITROM;
        S_WAITROM: w_state_nxt = S_DECODE;
        // The end marker shares reg 8'hFF with delay opcodes, so it must be tested first
        S_DECODE: begin
          if (io_bus.tbl_data == C_END_MARK) begin
            w_state_nxt = S_DONE;
          end else if (io_bus.tbl_data[15:8] == 8'hFF) begin
            if (w_dly_cnt == {CNT_W{1'b0}}) begin
              w_state_nxt = S_NEXT;
            end else begin
              w_state_nxt = S_DLY;
              w_cnt_nxt   = w_dly_cnt;
            end
          end else begin
            w_state_nxt = S_ISSUE;
            w_reg_nxt   = io_bus.tbl_data[15:8];
            w_val_nxt   = io_bus.tbl_data[7:0];
          end
        end
        S_ISSUE: begin
          if (io_bus.wr_ready) begin
            w_state_nxt = S_WAITW;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
        S_WAITW: begin
          if (io_bus.wr_done) begin
`ifdef SCCB_RETRY_EN
            if (!io_bus.wr_nack) begin
              w_state_nxt = S_NEXT;
            end else if (r_retry < C_RETRY_LIM) begin
              w_state_nxt = S_ISSUE;
              w_retry_nxt = r_retry + 1'b1;
            end else begin
              w_state_nxt = S_ERR;
            end
`else
            w_state_nxt = S_NEXT;
`endif
          end else begin
            w_state_nxt = S_WAITW;
          end
        end
        S_DLY: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_NEXT;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (r_entry_idx == C_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
            w_entry_nxt = r_entry_idx + 1'b1;
`ifdef SCCB_RETRY_EN
            w_retry_nxt = {RTY_W{1'b0}};
`endif
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        S_ERR:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, datapath and output registers; outputs are decoded from the next state so they align with it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_entry_idx <= {TBL_AW{1'b0}};
      r_tbl_addr  <= {TBL_AW{1'b0}};
      r_wr_reg    <= 8'h00;
      r_wr_val    <= 8'h00;
      r_wr_valid  <= 1'b0;
      r_cam_pwdn  <= 1'b1;
      r_cam_rst_n <= 1'b1;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_auto      <= 1'b1;
      r_edge      <= 1'b0;
`ifdef SCCB_RETRY_EN
      r_retry     <= {RTY_W{1'b0}};
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_entry_idx <= w_entry_nxt;
      r_tbl_addr  <= w_entry_nxt;
      r_wr_reg    <= w_reg_nxt;
      r_wr_val    <= w_val_nxt;
      r_wr_valid  <= (w_state_nxt == S_ISSUE);
      r_cam_pwdn  <= (w_state_nxt == S_PRE) ? 1'b0 : r_cam_pwdn;
      r_cam_rst_n <= (w_state_nxt != S_RSTL);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
      r_auto      <= 1'b0;
      r_edge      <= r_ov_s2 ^ r_ov_s3;
      if (r_edge) begin
        r_init_done <= 1'b0;
      end else if (w_state_nxt == S_DONE) begin
        r_init_done <= 1'b1;
      end else begin
        r_init_done <= r_init_done;
      end
`ifdef SCCB_RETRY_EN
      r_retry <= w_retry_nxt;
      if (r_edge) begin
        r_init_err <= 1'b0;
      end else if (w_state_nxt == S_ERR) begin
        r_init_err <= 1'b1;
      end else begin
        r_init_err <= r_init_err;
      end
`else
      r_init_err <= 1'b0;
`endif
    end
  end

  assign io_bus.tbl_addr = r_tbl_addr;
  assign io_bus.wr_valid = r_wr_valid;
  assign io_bus.wr_reg   = r_wr_reg;
  assign io_bus.wr_val   = r_wr_val;
  assign o_cam_pwdn      = r_cam_pwdn;
  assign o_cam_rst_n     = r_cam_rst_n;
  assign o_busy          = r_busy;
  assign o_init_done     = r_init_done;
  assign o_init_err      = r_init_err;
  assign o_entry_idx     = r_entry_idx;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Scoreboard bench for sccb_init_seq: a table-walk reference model feeds an expected-write queue,
// and an independent monitor checks every handshake, stall stability and timing against it.
`timescale 1ns/1ps
module tb_sccb_init_seq;
  localparam int TBL_AW = 4, NUM_ENTRIES = 4, PRE = 10, LOW = 20, POST = 30, DU = 5, MAX_RETRY = 2;

  logic clk = 1'b0, rst_n = 1'b0, init_ov = 1'b0;
  logic cam_pwdn, cam_rst_n, busy, init_done, init_err;
  logic [TBL_AW-1:0] entry_idx;

  sccb_init_seq_if #(.TBL_AW(TBL_AW)) bus ();

  sccb_init_seq #(
    .TBL_AW(TBL_AW), .NUM_ENTRIES(NUM_ENTRIES), .RST_PRE_CYC(PRE), .RST_LOW_CYC(LOW),
    .RST_POST_CYC(POST), .DELAY_UNIT(DU), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_ov(init_ov), .io_bus(bus),
    .o_cam_pwdn(cam_pwdn), .o_cam_rst_n(cam_rst_n), .o_busy(busy),
    .o_init_done(init_done), .o_init_err(init_err), .o_entry_idx(entry_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [16];
  always @(posedge clk) bus.tbl_data <= rom[bus.tbl_addr];

  int errors = 0, checks = 0;
  logic [15:0] exp_q[$];
  bit nack_q[$];
  int nk[NUM_ENTRIES];
  bit exp_done, exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: one full walk of the table, listing every write and its NACK answer
  task automatic model_pass();
    logic [15:0] e;
    int tries;
    exp_done = 1'b1;
    exp_err  = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      e = rom[i];
      if (e == 16'hFFFE) break;
      if (e[15:8] == 8'hFF) continue;
`ifdef SCCB_RETRY_EN
      tries = (nk[i] > MAX_RETRY) ? MAX_RETRY + 1 : nk[i] + 1;
      for (int k = 0; k < tries; k++) begin
        exp_q.push_back(e);
        nack_q.push_back(k < nk[i]);
      end
      if (nk[i] > MAX_RETRY) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
        break;
      end
`else
      tries = 1;
      exp_q.push_back(e);
      nack_q.push_back(nk[i] > 0);
`endif
    end
  endtask

  // SCCB engine model
  int  hold_cnt = 0, lat_fix = 2, done_cnt = 0, hs_count = 0, stall_cnt = 0;
  bit  rnd_ready = 1'b0, rnd_lat = 1'b0, pend_nack = 1'b0, hs_flag = 1'b0;
  initial begin
    bus.wr_ready = 1'b0; bus.wr_done = 1'b0; bus.wr_nack = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.wr_done = 1'b0; bus.wr_nack = 1'b0;
      if (hs_flag) begin
        hs_flag   = 1'b0;
        done_cnt  = rnd_lat ? $urandom_range(1, 5) : lat_fix;
        pend_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          bus.wr_done = 1'b1;
          bus.wr_nack = pend_nack;
        end
      end
      if (hold_cnt > 0) begin
        bus.wr_ready = 1'b0;
        if (bus.wr_valid) hold_cnt--;
      end else begin
        bus.wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: scoreboard pop per handshake, plus valid/data stability across stalls
  logic [15:0] prev_pair = 16'h0000;
  bit prev_stall = 1'b0, allow_drop = 1'b0;
  always @(negedge clk) begin
    if (bus.wr_valid && bus.wr_ready) begin
      hs_flag = 1'b1;
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_extra: got %h expected no write", {bus.wr_reg, bus.wr_val});
      end else begin
        chk("write", {bus.wr_reg, bus.wr_val}, exp_q.pop_front());
      end
    end
    if (bus.wr_valid && !bus.wr_ready) stall_cnt++;
    if (prev_stall && rst_n && !allow_drop) begin
      chk("stall_valid", bus.wr_valid, 1'b1);
      chk("stall_data", {bus.wr_reg, bus.wr_val}, prev_pair);
    end
    prev_stall = bus.wr_valid && !bus.wr_ready;
    prev_pair  = {bus.wr_reg, bus.wr_val};
  end

  // Timing monitor
  int cyc = 0, t_busy = 0, t_rstf = 0, t_rstr = 0, t_val1 = -1, t_done = 0, gap2 = -1, rst_falls = 0;
  bit p_busy = 1'b0, p_rst = 1'b1, p_val = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (busy && !p_busy) t_busy = cyc;
    if (!cam_rst_n && p_rst) begin t_rstf = cyc; rst_falls++; end
    if (cam_rst_n && !p_rst) t_rstr = cyc;
    if (bus.wr_valid && !p_val) begin
      if (t_val1 < 0) t_val1 = cyc;
      if (hs_count == 1) gap2 = cyc - t_done;
    end
    if (bus.wr_done) t_done = cyc;
    p_busy = busy; p_rst = cam_rst_n; p_val = bus.wr_valid;
  end

  task automatic check_rst_vals();
    chk("rst_pwdn", cam_pwdn, 1'b1);
    chk("rst_cam_rst_n", cam_rst_n, 1'b1);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    chk("rst_wr_reg", bus.wr_reg, 8'h00);
    chk("rst_wr_val", bus.wr_val, 8'h00);
    chk("rst_tbl_addr", bus.tbl_addr, 4'h0);
    chk("rst_entry_idx", entry_idx, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_init_err", init_err, 1'b0);
  endtask

  task automatic do_reset();
    allow_drop = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp_q.delete(); nack_q.delete();
    done_cnt = 0; hold_cnt = 0; hs_flag = 1'b0; hs_count = 0; stall_cnt = 0;
    t_val1 = -1; gap2 = -1;
    check_rst_vals();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    allow_drop = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!((init_done || init_err) && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("end_reached", k < budget, 1'b1);
    chk("init_done", init_done, exp_done);
    chk("init_err", init_err, exp_err);
    chk("busy_end", busy, 1'b0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic load_tbl(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic run(input int budget);
    do_reset();
    model_pass();
    release_rst();
    wait_end(budget);
  endtask

  initial begin
    int g0, g3, rf, k, r;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    for (int i = 0; i < NUM_ENTRIES; i++) nk[i] = 0;

    // Power-up timing and in-order writes
    load_tbl(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    run(500);
    chk("pre_cycles", t_rstf - t_busy, PRE);
    chk("rstl_cycles", t_rstr - t_rstf, LOW);
    chk("post_min", (t_val1 - t_rstr) >= POST, 1'b1);
    chk("pwdn_low", cam_pwdn, 1'b0);
    chk("hs_count4", hs_count, 4);

    // Delay opcode: a 3-unit delay adds exactly 15 cycles over a zero delay
    load_tbl(16'h1234, 16'hFF00, 16'h5678, 16'hFFFE);
    run(500);
    g0 = gap2;
    load_tbl(16'h1234, 16'hFF03, 16'h5678, 16'hFFFE);
    run(500);
    g3 = gap2;
    chk("dly_gap", g3 - g0, 15);
    chk("end_marker_writes", hs_count, 2);

    // Backpressure on the first write
    load_tbl(16'h2211, 16'h4433, 16'h6655, 16'h8877);
    do_reset();
    model_pass();
    hold_cnt = 7;
    release_rst();
    wait_end(500);
    chk("bp_stall", stall_cnt, 7);
    chk("bp_hs", hs_count, 4);

    // NACK handling
    load_tbl(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
`ifdef SCCB_RETRY_EN
    nk[1] = 2;
    run(800);
    chk("retry_hs", hs_count, 6);
    nk[1] = 3;
    run(800);
    chk("retry_err_hs", hs_count, 4);
`else
    nk[1] = 1;
    run(800);
    chk("nack_ign_hs", hs_count, 4);
`endif
    nk[1] = 0;

    // Randomised tables, backpressure and latency
    rnd_ready = 1'b1; rnd_lat = 1'b1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6 || r == 9) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        else if (r < 8)      rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
        else                 rom[i] = 16'hFFFE;
        r = $urandom_range(0, 7);
        nk[i] = (r < 5) ? 0 : r - 4;
      end
      run(1500);
    end
    rnd_ready = 1'b0; rnd_lat = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) nk[i] = 0;

    // Restart while the 3rd write is pending
    load_tbl(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    do_reset();
    model_pass();
    release_rst();
    k = 0;
    while (hs_count < 2 && k < 500) begin @(negedge clk); k++; end
    chk("wait_hs2", hs_count, 2);
    hold_cnt = 1000;
    k = 0;
    while (!bus.wr_valid && k < 50) begin @(negedge clk); k++; end
    chk("third_valid", bus.wr_valid, 1'b1);
    @(negedge clk);
    allow_drop = 1'b1;
    rf = rst_falls;
    init_ov = ~init_ov;
    k = 0;
    while (bus.wr_valid && k < 20) begin @(negedge clk); k++; end
    chk("abort_drop_fast", k <= 6, 1'b1);
    exp_q.delete(); nack_q.delete();
    model_pass();
    hold_cnt = 0;
    @(negedge clk);
    allow_drop = 1'b0;
    chk("abort_done_clr", init_done, 1'b0);
    chk("abort_busy", busy, 1'b1);
    wait_end(500);
    chk("restart_rst_pulse", rst_falls, rf + 1);
    chk("restart_hs", hs_count, 6);

    // Restart after DONE
    model_pass();
    init_ov = ~init_ov;
    k = 0;
    while (init_done && k < 20) begin @(negedge clk); k++; end
    chk("redo_done_clr", init_done, 1'b0);
    wait_end(500);
    chk("redo_hs", hs_count, 10);

    // Reset in the middle of a delay opcode
    load_tbl(16'h1234, 16'hFF0A, 16'h5678, 16'h9ABC);
    do_reset();
    model_pass();
    release_rst();
    k = 0;
    while (hs_count < 1 && k < 500) begin @(negedge clk); k++; end
    chk("wait_hs1", hs_count, 1);
    repeat (20) @(negedge clk);
    chk("mid_dly_busy", busy, 1'b1);
    run(800);
    chk("post_rst_hs", hs_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
